// File: rtl/alu_multicycle_pkg.sv
// Shared ALUControl encodings and FSM state type for the decoder and the multi-cycle ALU.
package alu_multicycle_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: add/sub, bitwise logic and set-less-than; reserved codes give 0.
module alu_comb_core
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle execute unit: one-cycle logic/arithmetic, bit-serial shifts, valid/ready on both sides.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  count_q, count_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] comb_y;
  logic [XLEN-1:0] shift_step;
  logic [SHW-1:0]  shamt;

  assign shamt = src_b[SHW-1:0];

  alu_comb_core #(
    .XLEN (XLEN)
  ) u_comb_core (
    .op_i (alu_control),
    .a_i  (src_a),
    .b_i  (src_b),
    .y_o  (comb_y)
  );

  // One bit of the latched shift per cycle.
  always_comb begin
    shift_step = result_q;
    case (op_q)
      ALU_SLL: shift_step = {result_q[XLEN-2:0], 1'b0};
      ALU_SRL: shift_step = {1'b0, result_q[XLEN-1:1]};
      ALU_SRA: shift_step = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: shift_step = result_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = alu_control;
          if (is_shift(alu_control)) begin
            result_d = src_a;
            count_d  = shamt;
            state_d  = (shamt == '0) ? StDone : StShift;
          end else begin
            result_d = comb_y;
            state_d  = StDone;
          end
        end
      end
      StShift: begin
        result_d = shift_step;
        count_d  = count_q - SHW'(1);
        if (count_q == SHW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= ALU_ADD;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule
